uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first, for the nanoV Tiny Tapeout top level, fed from the `uart_rxd` pad (`uio_in[5]`). It synchronises the line, validates the start bit at mid-bit, samples eight data bits and the stop bit, and pushes good bytes into a small FIFO. The CPU side reads that FIFO through a valid/read handshake, and sticky overrun and framing-error flags report lost data. It is the receive counterpart of the existing `uart_tx` and uses the same parameter set.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the nanoV UART blocks (uart_tx / uart_rx).
//   - default core clock and line rate
//   - clocks-per-bit / half-bit derivation
//   - receiver FSM state encoding
package uart_pkg;

  localparam int DEF_CLK_HZ   = 24_000_000;
  localparam int DEF_BIT_RATE = 115_200;

  // Integer division: the residual error is absorbed by mid-bit sampling.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  function automatic int half_bit(input int clk_hz, input int bit_rate);
    return cycles_per_bit(clk_hz, bit_rate) / 2;
  endfunction

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous FIFO holding received bytes.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset (storage cleared too)
//   push_i, data_i     : write request and data
//   pop_i              : read request, ignored when empty
//   data_o             : entry at the head (reads 0 after reset)
//   empty_o, full_o    : occupancy status
// A pop and a push in the same cycle on a full FIFO both succeed: the pop
// frees the slot the push lands in.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;
  logic             pop_ok, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign data_o  = mem_q[rd_q];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_ok) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, with receive FIFO.
// Ports:
//   clk, resetn   : clock, asynchronous active-low reset
//   uart_rxd      : serial line (idle high, asynchronous)
//   rx_data       : byte at FIFO head, valid while rx_valid
//   rx_valid      : FIFO not empty
//   rx_read       : pop FIFO head (ignored when empty)
//   rx_overrun    : sticky, a completed byte was dropped on a full FIFO
//   rx_frame_err  : sticky, a stop bit was sampled low
//   err_clear     : clears both sticky flags (a same-cycle set wins)
//   rx_busy       : FSM not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = DEF_CLK_HZ,
  parameter int BIT_RATE   = DEF_BIT_RATE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_read,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       err_clear,
  output logic       rx_busy
);

  localparam int CPB  = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int HALF = half_bit(CLK_HZ, BIT_RATE);
  localparam int CW   = $clog2(CPB);

  logic       sync1_q, rxs_q, rxs_d_q;
  logic [2:0] real_q;
  rx_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] sh_q, sh_d;
  logic       ovr_q, fe_q;
  logic       push, frame_set, ovr_set;
  logic       fifo_empty, fifo_full;

  // Synchroniser and edge-detect delay. real_q marks when rxs_d carries a
  // genuine line sample rather than a reset value, so a line that is still
  // low after reset release does not look like a falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      rxs_d_q <= 1'b1;
      real_q  <= '0;
    end else begin
      sync1_q <= uart_rxd;
      rxs_q   <= sync1_q;
      rxs_d_q <= rxs_q;
      real_q  <= {real_q[1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= RX_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      bidx_q <= '0;
      sh_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      bidx_q <= bidx_d;
      sh_q   <= sh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    case (state_q)
      RX_IDLE: begin
        if (real_q[2] && rxs_d_q && !rxs_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          if (rxs_q) begin
            state_d = RX_IDLE;  // false start
          end else begin
            state_d = RX_DATA;
            cnt_d   = '0;
            bidx_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(CPB - 1)) begin
          sh_d   = {rxs_q, sh_q[7:1]};  // LSB arrives first, ends in bit 0
          cnt_d  = '0;
          bidx_d = bidx_q + 3'd1;
          if (bidx_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(CPB - 1)) begin
          // Returning to IDLE at mid-stop leaves half a bit of slack.
          state_d = rxs_q ? RX_IDLE : RX_WAIT_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        // A held-low break must not re-trigger as a stream of starts.
        if (rxs_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    frame_set = 1'b0;
    rx_busy   = (state_q != RX_IDLE);
    if (state_q == RX_STOP && cnt_q == CW'(CPB - 1)) begin
      push      = rxs_q;
      frame_set = !rxs_q;
    end
  end

  // A pop on the push cycle frees a slot, so only a true full drops.
  assign ovr_set = push && fifo_full && !(rx_read && !fifo_empty);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ovr_q <= ovr_set   | (ovr_q & ~err_clear);
      fe_q  <= frame_set | (fe_q  & ~err_clear);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .data_i  (sh_q),
    .pop_i   (rx_read),
    .data_o  (rx_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rx_valid     = !fifo_empty;
  assign rx_overrun   = ovr_q;
  assign rx_frame_err = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at default parameters (CPB 208).
module tb_uart_rx;

  localparam int CPB      = 208;
  localparam int HALF     = 104;
  localparam int STOP_SMP = 3 + HALF + 9 * CPB;  // pin fall -> stop sample edge

  logic       clk = 1'b0;
  logic       resetn;
  logic       uart_rxd;
  logic       rx_read;
  logic       err_clear;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_busy;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  int         t0     = 0;
  int         rise_cyc = -1;
  logic [7:0] rise_data = '0;
  logic       vld_prev = 1'b0;
  logic [7:0] exp_q [$];

  uart_rx dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_read      (rx_read),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .err_clear    (err_clear),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && !vld_prev) begin
      rise_cyc  <= cyc;
      rise_data <= rx_data;
    end
    vld_prev <= rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One 8N1 frame. read_at / clr_at: frame cycle index on which rx_read /
  // err_clear is held high (-1 for none); a read pops the scoreboard head.
  task automatic send_byte(input logic [7:0] b, input bit stop_ok,
                           input int read_at, input int clr_at);
    logic [9:0] fr;
    logic [3:0] bi;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      bi        = 4'(i / CPB);
      uart_rxd  = fr[bi];
      rx_read   = (i == read_at);
      err_clear = (i == clr_at);
      if (i == read_at) begin
        if (exp_q.size() == 0) chk("read_unexpected", 32'(rx_valid), 32'd0);
        else chk("read_on_push_head", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
    @(posedge clk); #1;
    rx_read   = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!rx_valid && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!rx_valid) begin
      chk({tag, "_timeout"}, 32'(rx_valid), 32'd1);
      return;
    end
    if (exp_q.size() == 0) chk({tag, "_unexpected"}, 32'(rx_valid), 32'd0);
    else chk(tag, 32'(rx_data), 32'(exp_q.pop_front()));
    @(posedge clk); #1; rx_read = 1'b1;
    @(posedge clk); #1; rx_read = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1; err_clear = 1'b1;
    @(posedge clk); #1; err_clear = 1'b0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn    = 1'b0;
    uart_rxd  = 1'b1;
    rx_read   = 1'b0;
    err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);
    chk("rst_frame_err", 32'(rx_frame_err), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    @(posedge clk); #1; resetn = 1'b1;
    repeat (5) @(posedge clk);

    // Good 0x55: latency and data.
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, -1, -1);
    @(negedge clk);
    chk("t1_valid_latency", 32'(rise_cyc - t0), 32'(STOP_SMP));
    chk("t1_data_at_rise", 32'(rise_data), 32'h55);
    chk("t1_overrun", 32'(rx_overrun), 32'd0);
    chk("t1_frame_err", 32'(rx_frame_err), 32'd0);
    pop_check("t1_pop");
    @(negedge clk);
    chk("t1_empty", 32'(rx_valid), 32'd0);

    // False start: 50 low cycles.
    @(posedge clk); #1; uart_rxd = 1'b0; t0 = cyc;
    repeat (50) @(posedge clk);
    #1; uart_rxd = 1'b1;
    @(negedge clk);
    chk("t2_busy_in_start", 32'(rx_busy), 32'd1);
    n = 0;
    while (rx_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t2_busy_drop", 32'(cyc - t0), 32'(3 + HALF));
    repeat (CPB) @(negedge clk);
    chk("t2_no_push", 32'(rx_valid), 32'd0);

    // Frame error, line held low, then a good byte.
    send_byte(8'hA3, 1'b0, -1, -1);
    n = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (!rx_busy) n++;
    end
    chk("t3_no_restart", 32'(n), 32'd0);
    chk("t3_frame_err", 32'(rx_frame_err), 32'd1);
    chk("t3_no_push", 32'(rx_valid), 32'd0);
    @(posedge clk); #1; uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    chk("t3_idle_after_high", 32'(rx_busy), 32'd0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, -1, -1);
    pop_check("t3_next_byte");
    @(negedge clk);
    chk("t3_fe_sticky", 32'(rx_frame_err), 32'd1);
    pulse_clear();
    @(negedge clk);
    chk("t3_fe_cleared", 32'(rx_frame_err), 32'd0);

    // Overrun: five bytes, no reads.
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1, -1, -1);
      if (b == 4) begin
        @(negedge clk);
        chk("t4_no_overrun_yet", 32'(rx_overrun), 32'd0);
      end
    end
    @(negedge clk);
    chk("t4_overrun", 32'(rx_overrun), 32'd1);
    for (int k = 0; k < 4; k++) pop_check("t4_pop");
    @(negedge clk);
    chk("t4_drained", 32'(rx_valid), 32'd0);
    pulse_clear();
    @(negedge clk);
    chk("t4_ovr_cleared", 32'(rx_overrun), 32'd0);

    // Full FIFO with a read on the push cycle.
    for (int b = 8'h11; b <= 8'h14; b++) begin
      exp_q.push_back(8'(b));
      send_byte(8'(b), 1'b1, -1, -1);
    end
    exp_q.push_back(8'h15);
    send_byte(8'h15, 1'b1, STOP_SMP - 1, -1);
    @(negedge clk);
    chk("t5_no_overrun", 32'(rx_overrun), 32'd0);
    for (int k = 0; k < 4; k++) pop_check("t5_pop");
    @(negedge clk);
    chk("t5_count_was_4", 32'(rx_valid), 32'd0);

    // err_clear on the frame-error cycle: set wins.
    send_byte(8'h5A, 1'b0, -1, STOP_SMP - 1);
    @(negedge clk);
    chk("t6_set_wins", 32'(rx_frame_err), 32'd1);
    chk("t6_no_push", 32'(rx_valid), 32'd0);
    @(posedge clk); #1; uart_rxd = 1'b1;
    repeat (20) @(posedge clk);

    // Reset mid-DATA of 0xF0 (low bits), then 0x9E.
    exp_q.push_back(8'h77);
    send_byte(8'h77, 1'b1, -1, -1);
    @(posedge clk); #1; uart_rxd = 1'b0;
    repeat (2 * CPB + HALF) @(posedge clk);
    @(negedge clk);
    chk("t7_busy_before_rst", 32'(rx_busy), 32'd1);
    chk("t7_valid_before_rst", 32'(rx_valid), 32'd1);
    resetn = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(rx_valid), 32'd0);
    chk("t7_rst_data", 32'(rx_data), 32'h00);
    chk("t7_rst_busy", 32'(rx_busy), 32'd0);
    chk("t7_rst_frame_err", 32'(rx_frame_err), 32'd0);
    chk("t7_rst_overrun", 32'(rx_overrun), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1; resetn = 1'b1;
    n = 0;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (rx_busy) n++;
    end
    chk("t7_low_not_start", 32'(n), 32'd0);
    @(posedge clk); #1; uart_rxd = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    chk("t7_nothing_queued", 32'(rx_valid), 32'd0);
    exp_q.push_back(8'h9E);
    send_byte(8'h9E, 1'b1, -1, -1);
    pop_check("t7_pop");
    @(negedge clk);
    chk("t7_only_one", 32'(rx_valid), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
